// File: rtl/axis_decim_pkg.sv
// Shared types, default geometry and helpers for the multi-channel AXI-Stream decimator.
package axis_decim_pkg;

  localparam int CHANNELS_DEF    = 4;
  localparam int DATA_WIDTH_DEF  = 12;
  localparam int RATIO_WIDTH_DEF = 16;
  localparam int SHIFT_WIDTH_DEF = 5;

  typedef enum logic {
    DECIM_DROP = 1'b0,
    DECIM_AVG  = 1'b1
  } decim_mode_t;

  // Accumulator must hold ratio_max full-scale samples without wrapping.
  function automatic int acc_width(input int dataWidth, input int ratioWidth);
    return dataWidth + ratioWidth;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(DATA_WIDTH_DEF, RATIO_WIDTH_DEF);

  function automatic logic [DATA_WIDTH_DEF-1:0] lane_sel(
    input logic [CHANNELS_DEF*DATA_WIDTH_DEF-1:0] bus,
    input int                                     k
  );
    return bus[k*DATA_WIDTH_DEF +: DATA_WIDTH_DEF];
  endfunction

endpackage

// File: rtl/decim_acc_lane.sv
// One lane of the boxcar averager: running sum, right shift and saturation to DATA_WIDTH.
module decim_acc_lane
  import axis_decim_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic                   i_add,
  input  logic [DATA_WIDTH-1:0]  i_sample,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_sat
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_shifted;

  // The outputs describe the sum including the sample presented this cycle,
  // so the completing beat of a group is folded in without an extra cycle.
  assign w_sum     = i_load ? ACC_WIDTH'(i_sample) : (r_acc + ACC_WIDTH'(i_sample));
  assign w_shifted = w_sum >> i_shift;
  assign o_sat     = |w_shifted[ACC_WIDTH-1:DATA_WIDTH];
  assign o_data    = o_sat ? '1 : w_shifted[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load || i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/axis_decimator_mc.sv
// Multi-channel AXI-Stream decimator: one output beat per group of `ratio` accepted
// input beats, either keeping the last beat (drop) or a shifted per-lane sum (average).
module axis_decimator_mc
  import axis_decim_pkg::*;
#(
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int RATIO_WIDTH = RATIO_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           mode,
  input  logic [RATIO_WIDTH-1:0]         ratio,
  input  logic [SHIFT_WIDTH-1:0]         avg_shift,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS-1:0]            m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);

  localparam int                     ACC_WIDTH = acc_width(DATA_WIDTH, RATIO_WIDTH);
  localparam logic [RATIO_WIDTH-1:0] RATIO_ONE = RATIO_WIDTH'(1);

  logic [RATIO_WIDTH-1:0]         r_cnt;
  logic [RATIO_WIDTH-1:0]         r_ratio;
  decim_mode_t                    r_mode;
  logic [SHIFT_WIDTH-1:0]         r_shift;
  logic [CHANNELS*DATA_WIDTH-1:0] r_data;
  logic [CHANNELS-1:0]            r_user;
  logic                           r_valid;

  logic                           w_first;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_complete;
  logic                           w_load;
  logic                           w_add;
  logic                           w_clear;
  logic [RATIO_WIDTH-1:0]         w_ratioIn;
  logic [RATIO_WIDTH-1:0]         w_ratioEff;
  decim_mode_t                    w_modeIn;
  decim_mode_t                    w_modeEff;
  logic [SHIFT_WIDTH-1:0]         w_shiftEff;
  logic [CHANNELS*DATA_WIDTH-1:0] w_avgData;
  logic [CHANNELS-1:0]            w_avgSat;

  // On the first beat of a group the live configuration is used and latched,
  // so a one-beat group is already governed by the values presented with it.
  assign w_first    = (r_cnt == '0);
  assign w_ratioIn  = (ratio == '0) ? RATIO_ONE : ratio;
  assign w_modeIn   = decim_mode_t'(mode);
  assign w_ratioEff = w_first ? w_ratioIn : r_ratio;
  assign w_modeEff  = w_first ? w_modeIn : r_mode;
  assign w_shiftEff = w_first ? avg_shift : r_shift;

  assign w_ready       = enable ? (!r_valid || m_axis_tready) : 1'b1;
  assign s_axis_tready = w_ready && !rst;
  assign w_accept      = s_axis_tvalid && w_ready && enable;
  assign w_complete    = w_accept && (r_cnt == (w_ratioEff - RATIO_ONE));
  assign w_load        = w_accept && w_first;
  assign w_add         = w_accept && !w_first;
  assign w_clear       = !enable;

  assign m_axis_tdata  = r_data;
  assign m_axis_tuser  = r_user;
  assign m_axis_tvalid = r_valid;

  // Group counter and shadow configuration; disabling abandons the current group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ratio <= RATIO_ONE;
      r_mode  <= DECIM_DROP;
      r_shift <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_complete ? '0 : (r_cnt + RATIO_ONE);
      if (w_first) begin
        r_ratio <= w_ratioIn;
        r_mode  <= w_modeIn;
        r_shift <= avg_shift;
      end
    end
  end

  // Single output stage; a pending beat survives enable dropping until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= '0;
    end else if (w_complete) begin
      r_valid <= 1'b1;
      if (w_modeEff == DECIM_AVG) begin
        r_data <= w_avgData;
        r_user <= w_avgSat;
      end else begin
        r_data <= s_axis_tdata;
        r_user <= '0;
      end
    end else if (m_axis_tready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    decim_acc_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_clear),
      .i_load   (w_load),
      .i_add    (w_add),
      .i_sample (s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_shift  (w_shiftEff),
      .o_data   (w_avgData[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_sat    (w_avgSat[k])
    );
  end

endmodule
